// File: rtl/masking_pkg.sv
// Shared encodings and index helpers for the HPC2 masked gate family.
package masking_pkg;

   localparam int OP_AND  = 0;
   localparam int OP_NAND = 1;
   localparam int OP_XOR  = 2;
   localparam int OP_XNOR = 3;

   function automatic int nr(input int d, input int w);
      return w * d * (d - 1) / 2;
   endfunction

   // Unordered share pair -> randomness slice, so r_ji and r_ij share one slice.
   function automatic int rnd_idx(input int i, input int j, input int d);
      int lo;
      int hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * d - lo * (lo + 1) / 2 + (hi - lo - 1);
   endfunction

   // Ordered pair (i != j) -> dense slot among the D*(D-1) cross terms.
   function automatic int pair_idx(input int i, input int j, input int d);
      return i * (d - 1) + ((j < i) ? j : j - 1);
   endfunction

endpackage

// File: rtl/hpc2_pair_cell.sv
// HPC2 cross-domain term for one ordered share pair (i,j), W bitsliced lanes.
module hpc2_pair_cell #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] a_p1,
   input  logic [W-1:0] b_j,
   input  logic [W-1:0] r_ij,
   output logic [W-1:0] uv_p2
);

   logic [W-1:0] r_p1;
   logic [W-1:0] bm_p1;
   (* keep = "true" *) logic [W-1:0] u_p2;
   (* keep = "true" *) logic [W-1:0] v_p2;

   // Stage 1: b_j is remasked by r_ij before it meets share i
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1  <= '0;
         bm_p1 <= '0;
      end else if (en) begin
         r_p1  <= r_ij;
         bm_p1 <= b_j ^ r_ij;
      end
   end

   // Stage 2: both products registered before any XOR compression
   always_ff @(posedge clk) begin
      if (rst) begin
         u_p2 <= '0;
         v_p2 <= '0;
      end else if (en) begin
         u_p2 <= ~a_p1 & r_p1;
         v_p2 <= a_p1 & bm_p1;
      end
   end

   assign uv_p2 = u_p2 ^ v_p2;

endmodule

// File: rtl/masked_gate_hpc2.sv
// D-share, W-lane masked two-input gate (AND/NAND via HPC2, XOR/XNOR share-wise),
// fixed two-register latency for every operation.
module masked_gate_hpc2
   import masking_pkg::*;
#(
   parameter int D  = 3,
   parameter int W  = 1,
   parameter int OP = OP_AND,
   parameter int NR = nr(D, W)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   input  logic [D*W-1:0]  a,
   input  logic [D*W-1:0]  b,
   input  logic [NR-1:0]   r,
   output logic [D*W-1:0]  c,
   output logic            out_valid
);

   localparam bit LINEAR = (OP == OP_XOR) || (OP == OP_XNOR);
   localparam bit NONLIN = (OP == OP_AND) || (OP == OP_NAND);
   localparam bit INV    = (OP == OP_NAND) || (OP == OP_XNOR);
   localparam logic [D*W-1:0] INV_MASK =
      INV ? {{(D*W-W){1'b0}}, {W{1'b1}}} : '0;

   logic [D*W-1:0] p_p1;
   logic           vld_p1;
   (* keep = "true" *) logic [D*W-1:0] p_p2;
   logic           vld_p2;
   logic [D*W-1:0] mix_p2;

   function automatic logic [D*W-1:0] diag_term(input logic [D*W-1:0] x,
                                                input logic [D*W-1:0] y);
      return LINEAR ? (x ^ y) : (x & y);
   endfunction

   // Stage 1: diagonal product (or share-wise XOR) and valid capture
   always_ff @(posedge clk) begin
      if (rst) begin
         p_p1   <= '0;
         vld_p1 <= 1'b0;
      end else if (en) begin
         p_p1   <= diag_term(a, b);
         vld_p1 <= in_valid;
      end
   end

   // Stage 2: share-0 inversion folded into the P2 load so a reset pipeline reads c = 0
   always_ff @(posedge clk) begin
      if (rst) begin
         p_p2   <= '0;
         vld_p2 <= 1'b0;
      end else if (en) begin
         p_p2   <= p_p1 ^ INV_MASK;
         vld_p2 <= vld_p1;
      end
   end

   generate
      if (NONLIN) begin : g_nonlin
         logic [D*W-1:0]       a_p1;
         logic [D*(D-1)*W-1:0] uv_p2;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_p1 <= '0;
            end else if (en) begin
               a_p1 <= a;
            end
         end

         for (genvar i = 0; i < D; i++) begin : g_row
            for (genvar j = 0; j < D; j++) begin : g_col
               if (i != j) begin : g_cell
                  localparam int K = rnd_idx(i, j, D);
                  localparam int S = pair_idx(i, j, D);
                  hpc2_pair_cell #(.W(W)) u_cell (
                     .clk   (clk),
                     .rst   (rst),
                     .en    (en),
                     .a_p1  (a_p1[i*W +: W]),
                     .b_j   (b[j*W +: W]),
                     .r_ij  (r[K*W +: W]),
                     .uv_p2 (uv_p2[S*W +: W])
                  );
               end
            end
         end

         always_comb begin
            mix_p2 = '0;
            for (int i = 0; i < D; i++) begin
               for (int j = 0; j < D; j++) begin
                  if (i != j) begin
                     mix_p2[i*W +: W] = mix_p2[i*W +: W] ^ uv_p2[pair_idx(i, j, D)*W +: W];
                  end
               end
            end
         end
      end else begin : g_linear
         logic unused_r;
         assign unused_r = ^r;
         assign mix_p2   = '0;
      end
   endgenerate

   assign c         = p_p2 ^ mix_p2;
   assign out_valid = vld_p2;

endmodule

// File: doc/masked_gate_hpc2.md
Name: masked_gate_hpc2

Overview:
- Parametrised HPC2 masked two-input gate: D shares, W bitsliced lanes per share.
- Selectable operation: AND, NAND, XOR, XNOR.
- Fixed 2-cycle latency for every operation, so linear and non-linear gates can be mixed freely in the masked datapath.
- Stall enable and valid tracking let the block drop into LWC cipher round pipelines unchanged.

Parameters:
- D, 3, number of shares (masking order D-1); legal range 2..8.
- W, 1, lanes per share (bitsliced width); range 1..64.
- OP, 0, operation: 0=AND, 1=NAND, 2=XOR, 3=XNOR.
- NR, W*D*(D-1)/2, random bits consumed per cycle. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  pipeline advance; when 0, every register holds.
- in_valid  in  1  a, b and r are meaningful this cycle.
- a  in  D*W  shares of operand a; share i = a[i*W+W-1 : i*W].
- b  in  D*W  shares of operand b, same layout as a.
- r  in  NR  fresh randomness; don't-care for OP=2/3.
- c  out  D*W  result shares, same layout as a.
- out_valid  out  1  c is valid.

Behaviour:
- Reset (rst=1 at a clk edge): every pipeline register clears to 0, including out_valid and c. rst overrides en.
- en=0: no register updates; c and out_valid hold.
- Latency: a, b, r and in_valid accepted on edge k (with en=1) produce c and out_valid on edge k+2, counting only enabled edges.
- Throughput: one operation per enabled cycle. Full pipelining, no backpressure beyond en.
- Randomness mapping:
  - Pair (i,j) with i<j uses index k = i*D - i*(i+1)/2 + (j-i-1).
  - Lane slice r[k*W+W-1 : k*W] is r_ij; r_ji = r_ij.
  - r must be fresh on every accepted cycle. The block does not check this.
- AND/NAND, stage 1 registers per lane:
  - A1_i = a_i
  - P1_i = a_i & b_i
  - R1_ij = r_ij
  - B1_ij = b_j ^ r_ij for all i != j
- AND/NAND, stage 2 registers:
  - U2_ij = ~A1_i & R1_ij
  - V2_ij = A1_i & B1_ij
  - P2_i = P1_i
- AND/NAND output (combinational from stage-2 registers only): c_i = P2_i ^ XOR over j != i of (U2_ij ^ V2_ij).
- No combinational path from any input to c.
- Correctness: XOR over i of c_i = a & b (unmasked), lane-wise.
- XOR/XNOR: c_i = a_i ^ b_i, passed through two register stages; r ignored.
- NAND/XNOR: share 0 of the result is inverted (bitwise NOT of the W lanes) after stage 2. Other shares are unchanged.
- out_valid is a 2-deep shift of in_valid, gated by en and cleared by rst.
- Data registers load regardless of in_valid. out_valid is the only qualifier.
- Glitch discipline:
  - Every product term is registered before XOR compression.
  - Synthesis must keep every register listed above. Apply a keep attribute on U2/V2/P2.
- Reset mid-operation: in-flight results are discarded. Operations accepted after the reset cycle see normal latency.

Decomposition:
- Shared package masking_pkg holds:
  - Operation encodings OP_AND/OP_NAND/OP_XOR/OP_XNOR.
  - A constant function nr(D,W) for the randomness width.
  - A function rnd_idx(i,j,D) for pair-to-index mapping.
- One natural sub-module, hpc2_pair_cell: the 2-stage U/V logic for one (i,j) pair over W lanes. Instantiate it for all D*(D-1) ordered pairs.
- The top level holds the diagonal P path, the linear path, output compression, share-0 inversion and the valid pipeline.

Test Plan:
- D=3, W=1, OP=AND, rst high two cycles -> c=000, out_valid=0. Then en=1, in_valid=1, a=3'b110 (value 0), b=3'b011 (value 0), r=3'b101 -> two edges later out_valid=1, XOR of c = 0.
- D=3, W=1, OP=AND: sweep all 64 a,b share combinations × 8 r values, back-to-back every cycle -> XOR(c) = XOR(a) & XOR(b) each cycle at fixed latency 2.
- D=4, W=8, OP=NAND: a shares = {8'h0F, 8'h00, 8'h00, 8'h00}, b shares = {8'hFF, 8'h00, 8'h00, 8'h00}, random r -> XOR(c) = 8'hF0.
- D=3, W=4, OP=XNOR: a = {4'hA, 4'h5, 4'h0}, b = {4'h3, 4'h0, 4'h0}, r = 0 -> c = {~(4'hA^4'h3), 4'h5, 4'h0} = {4'h6, 4'h5, 4'h0}, latency 2.
- Stall: issue op on edge k, en=0 for 3 cycles, then en=1 -> c and out_valid unchanged during the stall; result appears 2 enabled edges after issue.
- Reset mid-flight: issue op, assert rst on the next edge together with en=1 -> out_valid stays 0. A fresh op issued after reset completes in 2 cycles.
